uart_rx: RTL

- Asynchronous serial receiver; the receive-side partner of the UART transmitter. It consumes the txd line that the transmitter drives.
- Frame formats match the transmitter exactly: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits. Baud period is set by the same baud_max_cnt value.
- Presents each received byte to the host logic with a valid/ack handshake plus parity, framing and overrun error flags.

---
 rtl/uart_rx.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: synchronised rxd, mid-bit sampling, 8N/E/O 1-2 stop,
// valid/ack host handshake with parity, framing and overrun flags.
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic [15:0] baud_max_cnt,
    input  logic [1:0]  parity_sel,
    input  logic        stop_sel,
    input  logic        rxd,
    input  logic        rx_ack,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun_err,
    output logic        busy
);

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [NS-1:0] sync_q;
    logic        rxd_s;
    logic        rxd_d;
    logic [15:0] cnt;
    logic [15:0] half;
    logic        at_half;
    logic        bit_end;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        par_bit;
    logic        stop_bad;
    logic        done_q;
    logic        par_bad;

    logic cnt_clr;
    logic shift_en;
    logic par_en;
    logic stop1_en;
    logic stop2_en;
    logic done_n;

    // Reset high so release never looks like a falling start edge
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            rxd_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[NS-2:0], rxd};
            rxd_d  <= rxd_s;
        end
    end

    assign rxd_s   = sync_q[NS-1];
    assign half    = baud_max_cnt >> 1;
    assign at_half = (cnt == half);
    assign bit_end = (cnt == baud_max_cnt);
    assign busy    = (state != IDLE);

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop1_en = 1'b0;
        stop2_en = 1'b0;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rxd_d && !rxd_s) begin
                    state_n = START;
                end
            end
            START: begin
                if (at_half) begin
                    if (!rxd_s) begin
                        state_n = DATA;
                        cnt_clr = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_n = (parity_sel != 2'b00) ? PARITY : STOP1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_en  = 1'b1;
                    state_n = STOP1;
                end
            end
            STOP1: begin
                if (bit_end) begin
                    stop1_en = 1'b1;
                    if (stop_sel) begin
                        state_n = STOP2;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (bit_end) begin
                    stop2_en = 1'b1;
                    state_n  = IDLE;
                    done_n   = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == IDLE || cnt_clr || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_bad <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= done_n;
            if (cnt_clr) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shreg <= {rxd_s, shreg[7:1]};
            end
            if (par_en) begin
                par_bit <= rxd_s;
            end
            if (stop1_en) begin
                stop_bad <= !rxd_s;
            end else if (stop2_en) begin
                stop_bad <= stop_bad | !rxd_s;
            end
        end
    end

    always_comb begin
        par_bad = 1'b0;
        unique case (parity_sel)
            2'b01:   par_bad = (par_bit != ^shreg);
            2'b10:   par_bad = (par_bit != ~^shreg);
            default: par_bad = 1'b0;
        endcase
    end

    // Completion outranks a same-cycle ack: the ack belongs to the old byte
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (done_q) begin
                rx_data     <= shreg;
                parity_err  <= par_bad;
                frame_err   <= stop_bad;
                rx_valid    <= 1'b1;
                overrun_err <= rx_valid && !rx_ack;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
